// File: rtl/i2c_bus_conditioner.sv
// I2C pad conditioner: synchronise + glitch-filter SCL/SDA, derive edge/START/STOP strobes, bus-busy and glitch count.
// Latency SYNC_STAGES+FILTER_CYCLES-1 clocks from first sampling edge; no backpressure, strobes are 1-cycle and must be taken when seen.
module i2c_bus_conditioner #(
    parameter int SYNC_STAGES         = 2,
    parameter int FILTER_CYCLES       = 4,
    parameter int IDLE_TIMEOUT_CYCLES = 0
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_scl,
    input  logic       in_sda,
    output logic       out_scl,
    output logic       out_sda,
    output logic       out_scl_rise,
    output logic       out_scl_fall,
    output logic       out_start,
    output logic       out_stop,
    output logic       out_bus_busy,
    output logic [7:0] out_glitch_cnt
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
    localparam logic [15:0] TO_LIMIT = 16'(IDLE_TIMEOUT_CYCLES);
    localparam int SCL = 0;
    localparam int SDA = 1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0][CW-1:0]          cnt_q, cnt_d;
    logic [1:0]                  filt_q, filt_d;
    logic [1:0]                  upd;
    logic [1:0]                  reject;
    logic [1:0]                  raw;

    logic       scl_rise_q, scl_rise_d;
    logic       scl_fall_q, scl_fall_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic [7:0] glitch_q, glitch_d;
    logic [8:0] glitch_sum;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic       timeout;
    state_t     state_q, state_d;

    assign raw = {in_sda, in_scl};

    // Per-line synchroniser and stability filter; index 0 is SCL, 1 is SDA.
    always_comb begin
        sync_d = sync_q;
        cnt_d  = cnt_q;
        filt_d = filt_q;
        upd    = '0;
        reject = '0;
        for (int i = 0; i < 2; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = ~filt_q[i];
                    cnt_d[i]  = '0;
                    upd[i]    = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (cnt_q[i] != '0) begin
                cnt_d[i]  = '0;
                reject[i] = 1'b1;
            end
        end
    end

    // Strobes are registered alongside the filtered level so they align with it.
    always_comb begin
        scl_rise_d = upd[SCL] & filt_d[SCL];
        scl_fall_d = upd[SCL] & ~filt_d[SCL];
        start_d    = upd[SDA] & ~filt_d[SDA] & filt_q[SCL] & ~upd[SCL];
        stop_d     = upd[SDA] & filt_d[SDA] & filt_q[SCL] & ~upd[SCL];
        glitch_sum = {1'b0, glitch_q} + 9'(reject[SCL]) + 9'(reject[SDA]);
        glitch_d   = glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
    end

    // Bus state follows the registered strobes, so busy lags START/STOP by one cycle.
    always_comb begin
        to_cnt_d = '0;
        timeout  = 1'b0;
        state_d  = state_q;
        if ((IDLE_TIMEOUT_CYCLES != 0) && (state_q == ST_BUSY) && filt_q[SCL] && filt_q[SDA]) begin
            if (to_cnt_q + 16'd1 == TO_LIMIT) begin
                timeout = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 16'd1;
            end
        end
        case (state_q)
            ST_IDLE: if (start_q) state_d = ST_BUSY;
            ST_BUSY: if (stop_q || timeout) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            sync_q     <= '1;
            cnt_q      <= '0;
            filt_q     <= '1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            glitch_q   <= '0;
            to_cnt_q   <= '0;
            state_q    <= ST_IDLE;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            glitch_q   <= glitch_d;
            to_cnt_q   <= to_cnt_d;
            state_q    <= state_d;
        end
    end

    assign out_scl        = filt_q[SCL];
    assign out_sda        = filt_q[SDA];
    assign out_scl_rise   = scl_rise_q;
    assign out_scl_fall   = scl_fall_q;
    assign out_start      = start_q;
    assign out_stop       = stop_q;
    assign out_bus_busy   = (state_q == ST_BUSY);
    assign out_glitch_cnt = glitch_q;

endmodule
